// File: rtl/rbm_result_reader_pkg.sv
// Shared types and elaboration helpers for the RBM result reader.
// Provides the reader FSM encoding and the label-width helper.
package rbm_result_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } rd_state_e;

  // Ceiling log2 that never returns less than one bit, so a one-class vector still has a label port.
  function automatic int clog2_min1(input int n);
    int w;
    int p;
    w = 32'sd1;
    p = 32'sd2;
    while (p < n) begin
      p = p * 32'sd2;
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rbm_result_reader_argmax_unit.sv
// One compare/select step of the sequential arg-max scan.
// Only a strictly greater signed candidate replaces the running best, so ties keep the lower index.
module rbm_argmax_unit
  import rbm_result_reader_pkg::*;
#(
  parameter int w_bitlength = 12,
  parameter int label_w     = 4
) (
  input  logic signed [w_bitlength-1:0] cand_score,
  input  logic        [label_w-1:0]     cand_idx,
  input  logic signed [w_bitlength-1:0] best_score,
  input  logic        [label_w-1:0]     best_idx,
  output logic signed [w_bitlength-1:0] next_score,
  output logic        [label_w-1:0]     next_idx
);

  // signed compare and select of the surviving candidate
  always_comb begin
    next_score = best_score;
    next_idx   = best_idx;
    if (cand_score > best_score) begin
      next_score = cand_score;
      next_idx   = cand_idx;
    end else begin
      next_score = best_score;
      next_idx   = best_idx;
    end
  end

endmodule

// File: rtl/rbm_result_reader.sv
// Captures the classifier score vector on a finish rise, scans it for the arg-max
// and presents label/max_score on a valid/ready handshake.
module rbm_result_reader
  import rbm_result_reader_pkg::*;
#(
  parameter int output_dim  = 10,
  parameter int w_bitlength = 12,
  parameter int label_w     = clog2_min1(output_dim)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              finish,
  input  logic [output_dim*w_bitlength-1:0] scores_port,
  output logic [label_w-1:0]                label,
  output logic [w_bitlength-1:0]            max_score,
  output logic                              label_valid,
  input  logic                              label_ready,
  output logic                              busy,
  output logic                              overrun
);

  localparam logic [label_w-1:0] last_idx  = label_w'(output_dim - 1);
  localparam logic [label_w-1:0] first_idx = label_w'(1);
  localparam rd_state_e          cap_state = (output_dim == 1) ? HOLD : SCAN;

  rd_state_e                     state_r, state_nxt_s;
  logic                          finish_d_r, armed_r;
  logic signed [w_bitlength-1:0] score_r    [output_dim];
  logic signed [w_bitlength-1:0] score_in_s [output_dim];
  logic [label_w-1:0]            idx_r, best_idx_r, next_idx_s, label_r;
  logic signed [w_bitlength-1:0] best_r, next_score_s;
  logic [w_bitlength-1:0]        max_score_r;
  logic                          label_valid_r, busy_r, overrun_r;
  logic                          trigger_s, capture_s, step_s, last_s, accept_s, drop_s;

  for (genvar i = 0; i < output_dim; i++) begin : g_unpack
    assign score_in_s[i] = $signed(scores_port[i*w_bitlength +: w_bitlength]);
  end

  // armed_r masks the first edge after reset release, so a finish already high is not a rise
  assign trigger_s = finish & ~finish_d_r & armed_r;
  assign last_s    = step_s & (idx_r == last_idx);

  rbm_argmax_unit #(.w_bitlength(w_bitlength), .label_w(label_w)) u_argmax (
    .cand_score (score_r[idx_r]),
    .cand_idx   (idx_r),
    .best_score (best_r),
    .best_idx   (best_idx_r),
    .next_score (next_score_s),
    .next_idx   (next_idx_s)
  );

  // next-state and control decode
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    step_s      = 1'b0;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          capture_s   = 1'b1;
          state_nxt_s = cap_state;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        step_s = 1'b1;
        drop_s = trigger_s;
        if (idx_r == last_idx) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      HOLD: begin
        if (label_ready) begin
          accept_s = 1'b1;
          if (trigger_s) begin
            capture_s   = 1'b1;
            state_nxt_s = cap_state;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          drop_s      = trigger_s;
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // capture, scan datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_r       <= 1'b0;
      finish_d_r    <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
      label_valid_r <= 1'b0;
      label_r       <= '0;
      max_score_r   <= '0;
      idx_r         <= '0;
      best_idx_r    <= '0;
      best_r        <= '0;
      for (int i = 0; i < output_dim; i++) score_r[i] <= '0;
    end else begin
      armed_r    <= 1'b1;
      finish_d_r <= finish;
      busy_r     <= (state_nxt_s != IDLE);
      if (drop_s) overrun_r <= 1'b1;
      if (capture_s) begin
        for (int i = 0; i < output_dim; i++) score_r[i] <= score_in_s[i];
        best_idx_r <= '0;
        best_r     <= score_in_s[0];
        idx_r      <= first_idx;
        if (output_dim == 1) begin
          label_r       <= '0;
          max_score_r   <= score_in_s[0];
          label_valid_r <= 1'b1;
        end else begin
          label_valid_r <= 1'b0;
        end
      end else if (step_s) begin
        best_idx_r <= next_idx_s;
        best_r     <= next_score_s;
        idx_r      <= idx_r + 1'b1;
        if (last_s) begin
          label_r       <= next_idx_s;
          max_score_r   <= next_score_s;
          label_valid_r <= 1'b1;
        end
      end else if (accept_s) begin
        label_valid_r <= 1'b0;
      end
    end
  end

  assign label       = label_r;
  assign max_score   = max_score_r;
  assign label_valid = label_valid_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_rbm_result_reader.sv
// Directed bench for rbm_result_reader: reset, arg-max, ties, overrun,
// back-to-back handoff and mid-scan reset with hand-computed expectations.
module tb_rbm_result_reader;

  logic         clock, reset, finish, label_ready;
  logic [119:0] scores_port;
  logic [3:0]   label;
  logic [11:0]  max_score;
  logic         label_valid, busy, overrun;
  int           pass_cnt = 0;
  int           chk_cnt  = 0;

  rbm_result_reader dut (
    .clock       (clock),
    .reset       (reset),
    .finish      (finish),
    .scores_port (scores_port),
    .label       (label),
    .max_score   (max_score),
    .label_valid (label_valid),
    .label_ready (label_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(input int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9);
    int v [10];
    v = '{s0, s1, s2, s3, s4, s5, s6, s7, s8, s9};
    for (int i = 0; i < 10; i++) scores_port[i*12 +: 12] = 12'(v[i]);
  endtask

  task automatic test_reset();
    reset = 1'b0; finish = 1'b1; label_ready = 1'b0;
    load(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    tick(2);
    chk_cnt++; if (label !== 4'd0) $display("FAIL rst_label: got %0d want 0", label); else pass_cnt++;
    chk_cnt++; if (max_score !== 12'd0) $display("FAIL rst_max: got %0h want 0", max_score); else pass_cnt++;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", label_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %0b want 0", overrun); else pass_cnt++;
    reset = 1'b1;
    tick(3);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL rst_release_valid: got %0b want 0", label_valid); else pass_cnt++;
    finish = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    load(5, -3, 100, 7, 0, 2047, -2048, 9, 1, 2);
    finish = 1'b1;
    tick(1);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy); else pass_cnt++;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL basic_valid_e0: got %0b want 0", label_valid); else pass_cnt++;
    tick(8);
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL basic_valid_e8: got %0b want 0", label_valid); else pass_cnt++;
    tick(1);
    chk_cnt++; if (label_valid !== 1'b1) $display("FAIL basic_valid_e9: got %0b want 1", label_valid); else pass_cnt++;
    chk_cnt++; if (label !== 4'd5) $display("FAIL basic_label: got %0d want 5", label); else pass_cnt++;
    chk_cnt++; if (max_score !== 12'h7FF) $display("FAIL basic_max: got %0h want 7ff", max_score); else pass_cnt++;
    label_ready = 1'b1;
    tick(1);
    label_ready = 1'b0;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL basic_accept_valid: got %0b want 0", label_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_accept_busy: got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (label !== 4'd5) $display("FAIL basic_retain_label: got %0d want 5", label); else pass_cnt++;
    tick(3);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_level_no_retrigger: got %0b want 0", busy); else pass_cnt++;
    finish = 1'b0;
    tick(1);
  endtask

  task automatic test_ties();
    load(-4, -4, -4, -1, -4, -4, -4, -4, -1, -4);
    finish = 1'b1;
    tick(10);
    chk_cnt++; if (label_valid !== 1'b1) $display("FAIL ties_valid: got %0b want 1", label_valid); else pass_cnt++;
    chk_cnt++; if (label !== 4'd3) $display("FAIL ties_label: got %0d want 3", label); else pass_cnt++;
    chk_cnt++; if (max_score !== 12'hFFF) $display("FAIL ties_max: got %0h want fff", max_score); else pass_cnt++;
    label_ready = 1'b1;
    tick(1);
    label_ready = 1'b0; finish = 1'b0;
    tick(1);
  endtask

  task automatic test_overrun();
    load(5, -3, 100, 7, 0, 2047, -2048, 9, 1, 2);
    finish = 1'b1;
    tick(1);
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 2047);
    finish = 1'b0;
    tick(1);
    finish = 1'b1;
    tick(1);
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_scan_overrun: got %0b want 1", overrun); else pass_cnt++;
    finish = 1'b0;
    tick(7);
    chk_cnt++; if (label_valid !== 1'b1) $display("FAIL ovr_valid: got %0b want 1", label_valid); else pass_cnt++;
    chk_cnt++; if (label !== 4'd5) $display("FAIL ovr_label: got %0d want 5", label); else pass_cnt++;
    chk_cnt++; if (max_score !== 12'h7FF) $display("FAIL ovr_max: got %0h want 7ff", max_score); else pass_cnt++;
    finish = 1'b1;
    tick(1);
    chk_cnt++; if (label_valid !== 1'b1) $display("FAIL ovr_hold_valid: got %0b want 1", label_valid); else pass_cnt++;
    chk_cnt++; if (label !== 4'd5) $display("FAIL ovr_hold_label: got %0d want 5", label); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL ovr_hold_busy: got %0b want 1", busy); else pass_cnt++;
    finish = 1'b0; label_ready = 1'b1;
    tick(1);
    label_ready = 1'b0;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL ovr_accept_valid: got %0b want 0", label_valid); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b want 1", overrun); else pass_cnt++;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_cleared: got %0b want 0", overrun); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    load(-4, -4, -4, -1, -4, -4, -4, -4, -1, -4);
    finish = 1'b1;
    tick(10);
    chk_cnt++; if (label !== 4'd3) $display("FAIL b2b_first_label: got %0d want 3", label); else pass_cnt++;
    load(5, -3, 100, 7, 0, 2047, -2048, 9, 1, 2);
    finish = 1'b0;
    tick(1);
    chk_cnt++; if (label_valid !== 1'b1) $display("FAIL b2b_hold_valid: got %0b want 1", label_valid); else pass_cnt++;
    label_ready = 1'b1; finish = 1'b1;
    tick(1);
    label_ready = 1'b0;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL b2b_accept_valid: got %0b want 0", label_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_recapture_busy: got %0b want 1", busy); else pass_cnt++;
    tick(9);
    chk_cnt++; if (label_valid !== 1'b1) $display("FAIL b2b_second_valid: got %0b want 1", label_valid); else pass_cnt++;
    chk_cnt++; if (label !== 4'd5) $display("FAIL b2b_second_label: got %0d want 5", label); else pass_cnt++;
    chk_cnt++; if (max_score !== 12'h7FF) $display("FAIL b2b_second_max: got %0h want 7ff", max_score); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %0b want 0", overrun); else pass_cnt++;
    label_ready = 1'b1;
    tick(1);
    label_ready = 1'b0; finish = 1'b0;
    tick(1);
  endtask

  task automatic test_mid_reset();
    load(5, -3, 100, 7, 0, 2047, -2048, 9, 1, 2);
    finish = 1'b1;
    tick(5);
    #2;
    reset = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL mid_valid: got %0b want 0", label_valid); else pass_cnt++;
    chk_cnt++; if (label !== 4'd0) $display("FAIL mid_label: got %0d want 0", label); else pass_cnt++;
    chk_cnt++; if (max_score !== 12'd0) $display("FAIL mid_max: got %0h want 0", max_score); else pass_cnt++;
    @(posedge clock);
    #1;
    reset = 1'b1; finish = 1'b0;
    tick(2);
    load(-5, -7, 3, 3, 12, -100, 11, 12, 0, 4);
    finish = 1'b1;
    tick(1);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_fresh_busy: got %0b want 1", busy); else pass_cnt++;
    tick(9);
    chk_cnt++; if (label_valid !== 1'b1) $display("FAIL mid_fresh_valid: got %0b want 1", label_valid); else pass_cnt++;
    chk_cnt++; if (label !== 4'd4) $display("FAIL mid_fresh_label: got %0d want 4", label); else pass_cnt++;
    chk_cnt++; if (max_score !== 12'd12) $display("FAIL mid_fresh_max: got %0h want c", max_score); else pass_cnt++;
    label_ready = 1'b1;
    tick(1);
    label_ready = 1'b0;
    chk_cnt++; if (label_valid !== 1'b0) $display("FAIL mid_fresh_accept: got %0b want 0", label_valid); else pass_cnt++;
  endtask

  initial begin
    scores_port = '0;
    test_reset();
    test_basic();
    test_ties();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
